systolic_mm_engine: RTL and testbench

//  Parametrised output-stationary systolic matrix multiplier with built-in controller: C[ROWS x COLS] = A[ROWS x K] * B[K x COLS].
//  K is selectable per job up to K_MAX. Operand streams use valid/ready handshakes and results use backpressure.
//  The block applies the diagonal input skew itself. It replaces free-running fixed-3x3 arrays in the ECG classifier datapath.

---
 rtl/sa_pkg.sv | 37 +++
 rtl/systolic_pe.sv | 46 ++++
 rtl/systolic_mm_engine.sv | 204 ++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Holds the controller state encoding, accumulator sizing and output clamping.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    OUTPUT
  } sa_state_t;

  localparam int SAT_W = 64;

  function automatic int acc_width(
    input int data_w,
    input int k_max
  );
    return 2 * data_w + $clog2(k_max);
  endfunction

  // Clamp is done at full width; the caller keeps the low out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_conv(
    input logic signed [SAT_W-1:0] acc,
    input int                      out_w,
    input bit                      saturate
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (!saturate) return acc;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: registered a/b forwarding
// plus a signed multiply-accumulate gated by operand valid.
module systolic_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       a_in,
  input  logic                    a_vld_in,
  input  logic [DATA_W-1:0]       b_in,
  input  logic                    b_vld_in,
  output logic [DATA_W-1:0]       a_out,
  output logic                    a_vld_out,
  output logic [DATA_W-1:0]       b_out,
  output logic                    b_vld_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = $signed(a_in) * $signed(b_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
      if (clr)
        acc <= '0;
      else if (a_vld_in && b_vld_in)
        acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic GEMM with job controller, input skew
// lines and row-by-row result readout under backpressure.
module systolic_mm_engine
  import sa_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DATA_W   = 8,
  parameter int K_MAX    = 16,
  parameter int OUT_W    = 16,
  parameter int SATURATE = 1,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_a,
  input  logic [COLS*DATA_W-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*OUT_W-1:0]  out_data,
  output logic [RW-1:0]          out_row,
  output logic                   out_last,
  output logic                   done
);

  localparam int ACC_W   = acc_width(DATA_W, K_MAX);
  localparam int DRAIN_N = ROWS + COLS - 1;
  localparam int DCW     = $clog2(DRAIN_N + 1);

  sa_state_t      state;
  sa_state_t      state_n;
  logic [KW-1:0]  k_lat;
  logic [KW-1:0]  beat_cnt;
  logic [KW-1:0]  k_clamp;
  logic [DCW-1:0] drain_cnt;
  logic           fire;
  logic           clr;
  logic           row_fire;
  logic           row_last;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUTPUT);
  assign fire      = in_valid && in_ready;
  assign clr       = (state == IDLE) && start;
  assign row_last  = (out_row == RW'(ROWS - 1));
  assign row_fire  = out_valid && out_ready;
  assign out_last  = out_valid && row_last;
  assign k_clamp   = (k_len > KW'(K_MAX)) ?
                     KW'(K_MAX) : k_len;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start)
          state_n = (k_len == '0) ? OUTPUT : LOAD;
      LOAD:
        if (fire && beat_cnt == k_lat - KW'(1))
          state_n = DRAIN;
      DRAIN:
        if (drain_cnt == DCW'(DRAIN_N - 1))
          state_n = OUTPUT;
      OUTPUT:
        if (row_fire && row_last)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k_lat     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      out_row   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      unique case (state)
        IDLE:
          if (start) begin
            k_lat     <= k_clamp;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            out_row   <= '0;
          end
        LOAD:
          if (fire)
            beat_cnt <= beat_cnt + KW'(1);
        DRAIN:
          drain_cnt <= drain_cnt + DCW'(1);
        OUTPUT:
          if (row_fire) begin
            if (row_last) begin
              out_row <= '0;
              done    <= 1'b1;
            end else begin
              out_row <= out_row + RW'(1);
            end
          end
        default: ;
      endcase
    end
  end

  logic [DATA_W-1:0]       a_h  [ROWS][COLS+1];
  logic                    av_h [ROWS][COLS+1];
  logic [DATA_W-1:0]       b_v  [ROWS+1][COLS];
  logic                    bv_v [ROWS+1][COLS];
  logic signed [ACC_W-1:0] acc  [ROWS][COLS];

  // Lane i of A waits i cycles; gaps travel as invalid zero bubbles.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    if (i == 0) begin : g_direct
      assign a_h[i][0]  = fire ? in_a[i*DATA_W +: DATA_W] : '0;
      assign av_h[i][0] = fire;
    end else begin : g_line
      logic [DATA_W-1:0] sr [i];
      logic [i-1:0]      sv;
      always_ff @(posedge clk) begin
        if (reset) begin
          sv <= '0;
          for (int t = 0; t < i; t++)
            sr[t] <= '0;
        end else begin
          sr[0] <= fire ? in_a[i*DATA_W +: DATA_W] : '0;
          sv[0] <= fire;
          for (int t = 1; t < i; t++) begin
            sr[t] <= sr[t-1];
            sv[t] <= sv[t-1];
          end
        end
      end
      assign a_h[i][0]  = sr[i-1];
      assign av_h[i][0] = sv[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew_b
    if (j == 0) begin : g_direct
      assign b_v[0][j]  = fire ? in_b[j*DATA_W +: DATA_W] : '0;
      assign bv_v[0][j] = fire;
    end else begin : g_line
      logic [DATA_W-1:0] sr [j];
      logic [j-1:0]      sv;
      always_ff @(posedge clk) begin
        if (reset) begin
          sv <= '0;
          for (int t = 0; t < j; t++)
            sr[t] <= '0;
        end else begin
          sr[0] <= fire ? in_b[j*DATA_W +: DATA_W] : '0;
          sv[0] <= fire;
          for (int t = 1; t < j; t++) begin
            sr[t] <= sr[t-1];
            sv[t] <= sv[t-1];
          end
        end
      end
      assign b_v[0][j]  = sr[j-1];
      assign bv_v[0][j] = sv[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .a_in      (a_h[i][j]),
        .a_vld_in  (av_h[i][j]),
        .b_in      (b_v[i][j]),
        .b_vld_in  (bv_v[i][j]),
        .a_out     (a_h[i][j+1]),
        .a_vld_out (av_h[i][j+1]),
        .b_out     (b_v[i+1][j]),
        .b_vld_out (bv_v[i+1][j]),
        .acc       (acc[i][j])
      );
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++)
      out_data[j*OUT_W +: OUT_W] = OUT_W'(sat_conv(
        SAT_W'(acc[out_row][j]), OUT_W, SATURATE != 0));
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench: 4x4 saturating, 4x4 wrapping and 3x3 engines
// share one operand stream and are checked against a golden GEMM.
module tb_systolic_mm_engine;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int OW = 16;
  localparam int KM = 16;
  localparam int KW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [R*DW-1:0] in_a = '0;
  logic [C*DW-1:0] in_b = '0;

  logic busy_m, in_ready_m, out_valid_m;
  logic out_last_m, done_m;
  logic [C*OW-1:0] out_data_m;
  logic [1:0]      out_row_m;

  logic busy_n, in_ready_n, out_valid_n;
  logic out_last_n, done_n;
  logic [C*OW-1:0] out_data_n;
  logic [1:0]      out_row_n;

  logic busy_3, in_ready_3, out_valid_3;
  logic out_last_3, done_3;
  logic [3*OW-1:0] out_data_3;
  logic [1:0]      out_row_3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc;

  int ga [R][KM];
  int gb [KM][C];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_mm_engine #(
    .ROWS(R), .COLS(C), .DATA_W(DW),
    .K_MAX(KM), .OUT_W(OW), .SATURATE(1)
  ) u_dut_m (
    .clk(clk), .reset(reset),
    .start(start), .k_len(k_len),
    .busy(busy_m),
    .in_valid(in_valid), .in_ready(in_ready_m),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_m), .out_ready(out_ready),
    .out_data(out_data_m), .out_row(out_row_m),
    .out_last(out_last_m), .done(done_m)
  );

  systolic_mm_engine #(
    .ROWS(R), .COLS(C), .DATA_W(DW),
    .K_MAX(KM), .OUT_W(OW), .SATURATE(0)
  ) u_dut_n (
    .clk(clk), .reset(reset),
    .start(start), .k_len(k_len),
    .busy(busy_n),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_data(out_data_n), .out_row(out_row_n),
    .out_last(out_last_n), .done(done_n)
  );

  systolic_mm_engine #(
    .ROWS(3), .COLS(3), .DATA_W(DW),
    .K_MAX(KM), .OUT_W(OW), .SATURATE(1)
  ) u_dut_3 (
    .clk(clk), .reset(reset),
    .start(start), .k_len(k_len),
    .busy(busy_3),
    .in_valid(in_valid), .in_ready(in_ready_3),
    .in_a(in_a[3*DW-1:0]), .in_b(in_b[3*DW-1:0]),
    .out_valid(out_valid_3), .out_ready(out_ready),
    .out_data(out_data_3), .out_row(out_row_3),
    .out_last(out_last_3), .done(done_3)
  );

  logic clr_mon = 1'b0;

  logic [C*OW-1:0] res_m [R];
  logic [C*OW-1:0] res_n [R];
  logic [3*OW-1:0] res_3 [3];
  int hs_m, hs_n, hs_3;
  int last_m, last_3, lrow_m, lrow_3;
  int dn_m, dn_n, dn_3;
  int first_v;
  logic [3:0] mask_m;
  logic [2:0] mask_3;

  always @(negedge clk) begin
    if (clr_mon) begin
      for (int i = 0; i < R; i++) res_m[i] <= '0;
      hs_m <= 0; last_m <= 0; lrow_m <= -1;
      dn_m <= 0; mask_m <= '0; first_v <= -1;
    end else begin
      if (out_valid_m && first_v < 0) first_v <= cyc;
      if (out_valid_m && out_ready) begin
        res_m[out_row_m]  <= out_data_m;
        mask_m[out_row_m] <= 1'b1;
        hs_m <= hs_m + 1;
        if (out_last_m) begin
          last_m <= last_m + 1;
          lrow_m <= int'(out_row_m);
        end
      end
      if (done_m) dn_m <= dn_m + 1;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      for (int i = 0; i < R; i++) res_n[i] <= '0;
      hs_n <= 0; dn_n <= 0;
    end else begin
      if (out_valid_n && out_ready) begin
        res_n[out_row_n] <= out_data_n;
        hs_n <= hs_n + 1;
      end
      if (done_n) dn_n <= dn_n + 1;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      for (int i = 0; i < 3; i++) res_3[i] <= '0;
      hs_3 <= 0; last_3 <= 0; lrow_3 <= -1;
      dn_3 <= 0; mask_3 <= '0;
    end else begin
      if (out_valid_3 && out_ready) begin
        res_3[out_row_3]  <= out_data_3;
        mask_3[out_row_3] <= 1'b1;
        hs_3 <= hs_3 + 1;
        if (out_last_3) begin
          last_3 <= last_3 + 1;
          lrow_3 <= int'(out_row_3);
        end
      end
      if (done_3) dn_3 <= dn_3 + 1;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] conv(input int v, input bit sat);
    int c;
    c = v;
    if (sat && c > 32767)  c = 32767;
    if (sat && c < -32768) c = -32768;
    return c[OW-1:0];
  endfunction

  function automatic logic [63:0] exp_row(
    input int i, input int k, input bit sat, input int nc
  );
    logic [63:0] r;
    int s;
    r = '0;
    for (int j = 0; j < nc; j++) begin
      s = 0;
      for (int t = 0; t < k; t++) s += ga[i][t] * gb[t][j];
      r[j*OW +: OW] = conv(s, sat);
    end
    return r;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < R; i++)
      for (int t = 0; t < KM; t++)
        ga[i][t] = int'($urandom_range(255)) - 128;
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < C; j++)
        gb[t][j] = int'($urandom_range(255)) - 128;
  endtask

  task automatic run_job(
    input int k, input bit gaps, input bit stall,
    input bit poke, input int abort
  );
    int b, guard, stop, st_cnt;
    bit fire, held, poked;
    logic [C*OW-1:0] held_d;
    logic [1:0]      held_r;
    clr_mon = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    clr_mon = 1'b0;
    start = 1'b1;
    k_len = KW'(k);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    stop = (abort >= 0) ? abort : k;
    b = 0;
    guard = 0;
    while (b < stop && guard < 200) begin
      in_valid = !gaps || (guard % 2 == 0);
      for (int i = 0; i < R; i++)
        in_a[i*DW +: DW] = DW'(ga[i][b]);
      for (int j = 0; j < C; j++)
        in_b[j*DW +: DW] = DW'(gb[b][j]);
      @(negedge clk);
      fire = in_valid && in_ready_m;
      @(posedge clk); #1;
      if (fire) b++;
      guard++;
    end
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    chk("beats", 64'(b), 64'(stop));
    if (abort >= 0) return;
    guard = 0; st_cnt = 0;
    held = 1'b0; poked = 1'b0;
    do begin
      out_ready = 1'b1;
      start = 1'b0;
      if (stall && out_valid_m && out_row_m == 2'd1 && st_cnt < 5) begin
        out_ready = 1'b0;
        if (!held) begin
          held = 1'b1;
          held_d = out_data_m;
          held_r = out_row_m;
        end else begin
          chk("hold_data", 64'(out_data_m), 64'(held_d));
          chk("hold_row", 64'(out_row_m), 64'(held_r));
        end
        st_cnt++;
      end
      if (poke && !poked && busy_m && !in_ready_m && !out_valid_m) begin
        start = 1'b1;
        k_len = '0;
        poked = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end while ((busy_m || busy_n || busy_3) && guard < 300);
    start = 1'b0;
    out_ready = 1'b1;
    chk("finish_in_time", 64'(guard < 300), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_results(input int k);
    for (int i = 0; i < R; i++) begin
      chk($sformatf("m_row%0d", i), 64'(res_m[i]),
          exp_row(i, k, 1'b1, C));
      chk($sformatf("n_row%0d", i), 64'(res_n[i]),
          exp_row(i, k, 1'b0, C));
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("s3_row%0d", i), 64'(res_3[i]),
          exp_row(i, k, 1'b1, 3));
    chk("m_handshakes", 64'(hs_m), 64'd4);
    chk("m_row_mask", 64'(mask_m), 64'hf);
    chk("m_last_cnt", 64'(last_m), 64'd1);
    chk("m_last_row", 64'(lrow_m), 64'd3);
    chk("m_done_cnt", 64'(dn_m), 64'd1);
    chk("n_handshakes", 64'(hs_n), 64'd4);
    chk("n_done_cnt", 64'(dn_n), 64'd1);
    chk("s3_handshakes", 64'(hs_3), 64'd3);
    chk("s3_row_mask", 64'(mask_3), 64'h7);
    chk("s3_last_row", 64'(lrow_3), 64'd2);
    chk("s3_done_cnt", 64'(dn_3), 64'd1);
  endtask

  logic [C*OW-1:0] saved [R];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy_m), 64'd0);
    chk("rst_in_ready", 64'(in_ready_m), 64'd0);
    chk("rst_out_valid", 64'(out_valid_m), 64'd0);
    chk("rst_done", 64'(done_m), 64'd0);
    chk("rst_out_data", 64'(out_data_m), 64'd0);

    // 3x3 A times identity
    for (int i = 0; i < R; i++)
      for (int t = 0; t < KM; t++) ga[i][t] = 0;
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < C; j++) gb[t][j] = 0;
    for (int i = 0; i < 3; i++)
      for (int t = 0; t < 3; t++) ga[i][t] = 3 * i + t + 1;
    for (int t = 0; t < 3; t++) gb[t][t] = 1;
    run_job(3, 1'b0, 1'b0, 1'b0, -1);
    chk("t1_row0", 64'(res_3[0]), 64'h0000_0003_0002_0001);
    chk("t1_row1", 64'(res_3[1]), 64'h0000_0006_0005_0004);
    chk("t1_row2", 64'(res_3[2]), 64'h0000_0009_0008_0007);
    chk("t1_last_cnt", 64'(last_3), 64'd1);
    check_results(3);

    // full-depth extreme operands
    for (int i = 0; i < R; i++)
      for (int t = 0; t < KM; t++) ga[i][t] = -128;
    for (int t = 0; t < KM; t++)
      for (int j = 0; j < C; j++) gb[t][j] = -128;
    run_job(16, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < R; i++) begin
      chk("t2_sat", 64'(res_m[i]), 64'h7fff_7fff_7fff_7fff);
      chk("t2_wrap", 64'(res_n[i]), 64'h0);
    end
    check_results(16);

    // backpressure on row 1
    fill_rand();
    run_job(5, 1'b0, 1'b1, 1'b0, -1);
    check_results(5);

    // continuous stream then gapped stream, same data
    fill_rand();
    run_job(7, 1'b0, 1'b0, 1'b0, -1);
    chk("latency", 64'(first_v - start_cyc), 64'd15);
    check_results(7);
    for (int i = 0; i < R; i++) saved[i] = res_m[i];
    run_job(7, 1'b1, 1'b0, 1'b0, -1);
    check_results(7);
    for (int i = 0; i < R; i++)
      chk("gap_vs_cont", 64'(res_m[i]), 64'(saved[i]));

    // reset after three beats
    fill_rand();
    run_job(7, 1'b0, 1'b0, 1'b0, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy_m), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready_m), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid_m), 64'd0);
    chk("mid_rst_data", 64'(out_data_m), 64'd0);
    fill_rand();
    run_job(6, 1'b0, 1'b0, 1'b0, -1);
    check_results(6);

    // start during DRAIN, then an empty job
    fill_rand();
    run_job(4, 1'b0, 1'b0, 1'b1, -1);
    check_results(4);
    run_job(0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < R; i++)
      chk("k0_zero", 64'(res_m[i]), 64'h0);
    check_results(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
